// File: rtl/aes_key_expander.sv
// AES-128 key-schedule engine: expands the 128-bit cipher key into round keys
// 1..10 and streams them, one 32-bit word per cycle, into round-key storage.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-high reset
//   start   - request expansion of key_in (accepted only when idle)
//   key_in  - cipher key, [127:96] is w[0]
//   busy    - high from the accepting edge until one cycle after done
//   done    - one-cycle pulse after the last word is written
//   WR_EN   - storage write strobe
//   index   - round number 1..10 of the word being written
//   blk_no  - word position within the round key, 0 = [127:96]
//   word    - round-key word
module aes_key_expander (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         WR_EN,
    output logic [3:0]   index,
    output logic [1:0]   blk_no,
    output logic [31:0]  word
);

    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned BLK_W   = 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(39);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Byte b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [KEY_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                busy_d, done_d, wr_en_d;
    logic [IDX_W-1:0]    index_d;
    logic [BLK_W-1:0]    blk_no_d;
    logic [WORD_W-1:0]   word_d;

    logic [WORD_W-1:0]   rot_word_c;
    logic [WORD_W-1:0]   sub_word_c;
    logic [WORD_W-1:0]   new_word_c;

    // Next schedule word from the sliding window w[i-4]..w[i-1].
    always_comb begin
        rot_word_c = {win_q[23:0], win_q[31:24]};
        sub_word_c = {sbox(rot_word_c[31:24]), sbox(rot_word_c[23:16]),
                      sbox(rot_word_c[15:8]),  sbox(rot_word_c[7:0])};
        if (cnt_q[1:0] == 2'd0) begin
            new_word_c = win_q[127:96] ^ sub_word_c ^ {rcon(cnt_q[5:2]), 24'h0};
        end else begin
            new_word_c = win_q[127:96] ^ win_q[31:0];
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        busy_d   = busy;
        done_d   = 1'b0;
        wr_en_d  = 1'b0;
        index_d  = index;
        blk_no_d = blk_no;
        word_d   = word;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    win_d   = key_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                busy_d   = 1'b1;
                wr_en_d  = 1'b1;
                word_d   = new_word_c;
                index_d  = cnt_q[5:2] + IDX_W'(1);
                blk_no_d = cnt_q[1:0];
                win_d    = {win_q[95:0], new_word_c};
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // busy stays high one more cycle so it drops right after done.
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            WR_EN   <= 1'b0;
            index   <= '0;
            blk_no  <= '0;
            word    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
            done    <= done_d;
            WR_EN   <= wr_en_d;
            index   <= index_d;
            blk_no  <= blk_no_d;
            word    <= word_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: key schedule checked against a GF(2^8)-derived
// reference model plus FIPS-197 constants, with sequencing and reset scenarios.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         WR_EN;
    logic [3:0]   index;
    logic [1:0]   blk_no;
    logic [31:0]  word;

    aes_key_expander dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .key_in (key_in),
        .busy   (busy),
        .done   (done),
        .WR_EN  (WR_EN),
        .index  (index),
        .blk_no (blk_no),
        .word   (word)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  sbox_m   [256];
    logic [31:0] model_w  [44];

    // Samples 1..42 taken after edges T1..T42.
    logic        cap_wr   [43];
    logic [3:0]  cap_idx  [43];
    logic [1:0]  cap_blk  [43];
    logic [31:0] cap_word [43];
    logic        cap_done [43];
    logic        cap_busy [43];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] bb = 8'(b);
            for (int c = 1; c < 256; c++) begin
                if (gmul(bb, 8'(c)) == 8'h01) inv = 8'(c);
            end
            sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) model_w[i] = 32'(key >> (96 - 32 * i));
        for (int i = 4; i < 44; i++) begin
            t = model_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            model_w[i] = model_w[i-4] ^ t;
        end
    endtask

    // Present start with key k; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [127:0] k);
        @(negedge clk);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
    endtask

    // Record 42 cycles of outputs after an accepted start.
    task automatic record_run(input bit hold_start, input bit chain_zero, input bit scramble_key);
        if (!hold_start) start = 1'b0;
        if (scramble_key) key_in = '1;
        for (int t = 1; t <= 42; t++) begin
            @(negedge clk);
            cap_wr[t]   = WR_EN;
            cap_idx[t]  = index;
            cap_blk[t]  = blk_no;
            cap_word[t] = word;
            cap_done[t] = done;
            cap_busy[t] = busy;
            if (t == 41) begin
                if (hold_start) start = 1'b0;
                if (chain_zero) begin
                    start  = 1'b1;
                    key_in = '0;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b1;
        key_in = FIPS_KEY;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, WR_EN} !== 3'b000)
            $display("FAIL reset_flags got %b expected 000", {busy, done, WR_EN});
        else n_pass++;
        n_checks++;
        if ({index, blk_no, word} !== 38'h0)
            $display("FAIL reset_data got %h expected 0", {index, blk_no, word});
        else n_pass++;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_fips();
        model_expand(FIPS_KEY);
        launch(FIPS_KEY);
        record_run(1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if ({cap_wr[t], cap_idx[t], cap_blk[t]} !== {1'b1, 4'((t - 1) / 4 + 1), 2'((t - 1) % 4)})
                $display("FAIL fips_seq t=%0d got wr=%b idx=%0d blk=%0d expected idx=%0d blk=%0d",
                         t, cap_wr[t], cap_idx[t], cap_blk[t], (t - 1) / 4 + 1, (t - 1) % 4);
            else n_pass++;
            n_checks++;
            if (cap_word[t] !== model_w[t + 3])
                $display("FAIL fips_word t=%0d got %h expected %h", t, cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
        n_checks++;
        if ({cap_word[1], cap_word[2], cap_word[3], cap_word[4]} !== 128'ha0fafe1788542cb123a339392a6c7605)
            $display("FAIL fips_round1 got %h%h%h%h", cap_word[1], cap_word[2], cap_word[3], cap_word[4]);
        else n_pass++;
        n_checks++;
        if ({cap_word[37], cap_word[38], cap_word[39], cap_word[40]} !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            $display("FAIL fips_round10 got %h%h%h%h", cap_word[37], cap_word[38], cap_word[39], cap_word[40]);
        else n_pass++;
        n_checks++;
        if ({cap_done[41], cap_wr[41], cap_busy[41]} !== 3'b101)
            $display("FAIL fips_t41 got done/wr/busy %b expected 101", {cap_done[41], cap_wr[41], cap_busy[41]});
        else n_pass++;
        n_checks++;
        if ({cap_done[42], cap_wr[42], cap_busy[42]} !== 3'b000)
            $display("FAIL fips_t42 got done/wr/busy %b expected 000", {cap_done[42], cap_wr[42], cap_busy[42]});
        else n_pass++;
    endtask

    task automatic test_zero_key();
        model_expand(128'h0);
        launch(128'h0);
        record_run(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({cap_word[1], cap_word[2], cap_word[3], cap_word[4]} !== 128'h62636363626363636263636362636363)
            $display("FAIL zero_round1 got %h%h%h%h", cap_word[1], cap_word[2], cap_word[3], cap_word[4]);
        else n_pass++;
        n_checks++;
        if ({cap_word[5], cap_word[6], cap_word[7], cap_word[8]} !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa)
            $display("FAIL zero_round2 got %h%h%h%h", cap_word[5], cap_word[6], cap_word[7], cap_word[8]);
        else n_pass++;
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if (cap_word[t] !== model_w[t + 3])
                $display("FAIL zero_word t=%0d got %h expected %h", t, cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        for (int r = 0; r < 4; r++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_expand(k);
            launch(k);
            record_run(1'b0, 1'b0, 1'b0);
            for (int t = 1; t <= 40; t++) begin
                n_checks++;
                if ({cap_wr[t], cap_idx[t], cap_blk[t], cap_word[t]} !==
                    {1'b1, 4'((t - 1) / 4 + 1), 2'((t - 1) % 4), model_w[t + 3]})
                    $display("FAIL rand_word key=%h t=%0d got idx=%0d blk=%0d w=%h expected w=%h",
                             k, t, cap_idx[t], cap_blk[t], cap_word[t], model_w[t + 3]);
                else n_pass++;
            end
            n_checks++;
            if (cap_done[41] !== 1'b1) $display("FAIL rand_done key=%h got %b expected 1", k, cap_done[41]);
            else n_pass++;
        end
    endtask

    task automatic test_start_held();
        model_expand(FIPS_KEY);
        launch(FIPS_KEY);
        record_run(1'b1, 1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if ({cap_wr[t], cap_idx[t], cap_blk[t], cap_word[t]} !==
                {1'b1, 4'((t - 1) / 4 + 1), 2'((t - 1) % 4), model_w[t + 3]})
                $display("FAIL held_word t=%0d got wr=%b idx=%0d blk=%0d w=%h expected w=%h",
                         t, cap_wr[t], cap_idx[t], cap_blk[t], cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
        n_checks++;
        if ({cap_done[41], cap_wr[41], cap_busy[42], cap_wr[42]} !== 4'b1000)
            $display("FAIL held_end got %b expected 1000",
                     {cap_done[41], cap_wr[41], cap_busy[42], cap_wr[42]});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        model_expand(FIPS_KEY);
        launch(FIPS_KEY);
        start = 1'b0;
        for (int t = 1; t <= 19; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, done, WR_EN, index, blk_no, word} !== 41'h0)
            $display("FAIL midreset_outputs got %h expected 0", {busy, done, WR_EN, index, blk_no, word});
        else n_pass++;
        reset = 1'b0;
        launch(FIPS_KEY);
        record_run(1'b0, 1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if ({cap_wr[t], cap_idx[t], cap_blk[t], cap_word[t]} !==
                {1'b1, 4'((t - 1) / 4 + 1), 2'((t - 1) % 4), model_w[t + 3]})
                $display("FAIL midreset_word t=%0d got idx=%0d blk=%0d w=%h expected w=%h",
                         t, cap_idx[t], cap_blk[t], cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        model_expand(FIPS_KEY);
        launch(FIPS_KEY);
        record_run(1'b0, 1'b1, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if (cap_word[t] !== model_w[t + 3])
                $display("FAIL b2b_first t=%0d got %h expected %h", t, cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
        n_checks++;
        if ({cap_done[41], cap_wr[42], cap_busy[42]} !== 3'b101)
            $display("FAIL b2b_handover got done/wr/busy %b expected 101",
                     {cap_done[41], cap_wr[42], cap_busy[42]});
        else n_pass++;
        model_expand(128'h0);
        record_run(1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({cap_wr[1], cap_idx[1], cap_blk[1], cap_word[1]} !== {1'b1, 4'd1, 2'd0, 32'h62636363})
            $display("FAIL b2b_t43 got wr=%b idx=%0d blk=%0d w=%h expected 1/1/0/62636363",
                     cap_wr[1], cap_idx[1], cap_blk[1], cap_word[1]);
        else n_pass++;
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if (cap_word[t] !== model_w[t + 3])
                $display("FAIL b2b_second t=%0d got %h expected %h", t, cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
    endtask

    task automatic test_key_change();
        model_expand(FIPS_KEY);
        launch(FIPS_KEY);
        record_run(1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 40; t++) begin
            n_checks++;
            if (cap_word[t] !== model_w[t + 3])
                $display("FAIL keychg_word t=%0d got %h expected %h", t, cap_word[t], model_w[t + 3]);
            else n_pass++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_random_keys();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        test_key_change();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
